// File: rtl/sha256_pkg.sv
// Shared constants and FSM state encoding for the SHA-256 stream master.
package sha256_pkg;

    localparam int DIGEST_W      = 256;
    localparam int DIGEST_BYTES  = 32;
    localparam int MAX_MSG_BYTES = 55;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        SEND    = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/sha256_msg_buf.sv
// Message byte buffer: one write port, one asynchronous read port, no reset.
module sha256_msg_buf #(
    parameter int DEPTH = 55,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_idx_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    // Byte storage; contents only matter after they are written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/sha256_stream_master.sv
// Buffers one message from a valid/ready source, replays it to the hasher as a
// gap-free strobe burst, then collects the 32 returned digest bytes.
//
// state   | meaning
// IDLE    | ready for the first byte of a new message
// COLLECT | storing bytes until msg_last
// SEND    | strobing buffered bytes to the hasher, one per cycle
// WAIT    | waiting for the first digest beat, timeout armed
// CAPTURE | shifting in digest beats
// DONE    | one-cycle digest_done pulse
module sha256_stream_master
    import sha256_pkg::*;
#(
    parameter int MAX_BYTES      = MAX_MSG_BYTES,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          msg_byte,
    input  logic                msg_valid,
    input  logic                msg_last,
    output logic                msg_ready,
    output logic [7:0]          hs_byte,
    output logic                hs_strobe,
    input  logic [7:0]          hs_dig_byte,
    input  logic                hs_dig_valid,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_done,
    output logic                busy,
    output logic                err_ovf,
    output logic                err_timeout,
    output logic                err_short
);

    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       rd_idx_q;
    logic [TW-1:0]       tmr_q;
    logic [5:0]          beat_q;
    logic [DIGEST_W-1:0] digest_q;
    logic [7:0]          hs_byte_q;
    logic                hs_strobe_q;
    logic                msg_ready_q;
    logic                digest_done_q;
    logic                busy_q;
    logic                err_ovf_q;
    logic                err_timeout_q;
    logic                err_short_q;

    logic                accept;
    logic                buf_we;
    logic [7:0]          buf_rd_data;
    logic [CW-1:0]       cnt_d;
    logic [DIGEST_W-1:0] digest_d;
    logic                last_beat;

    assign accept    = msg_valid && msg_ready_q;
    assign buf_we    = accept && (cnt_q < CW'(MAX_BYTES));
    assign cnt_d     = cnt_q + CW'(1);
    assign digest_d  = {digest_q[DIGEST_W-9:0], hs_dig_byte};
    assign last_beat = (beat_q == 6'(DIGEST_BYTES - 1));

    sha256_msg_buf #(
        .DEPTH (MAX_BYTES),
        .AW    (CW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_idx_i  (cnt_q),
        .wr_data_i (msg_byte),
        .rd_idx_i  (rd_idx_q),
        .rd_data_o (buf_rd_data)
    );

    // Sequencer: collect, replay, wait, capture; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_idx_q      <= '0;
            tmr_q         <= '0;
            beat_q        <= '0;
            digest_q      <= '0;
            hs_byte_q     <= '0;
            hs_strobe_q   <= 1'b0;
            msg_ready_q   <= 1'b0;
            digest_done_q <= 1'b0;
            busy_q        <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_short_q   <= 1'b0;
        end else begin
            digest_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    msg_ready_q <= 1'b1;
                    if (accept) begin
                        cnt_q  <= CW'(1);
                        busy_q <= 1'b1;
                        if (msg_last) begin
                            // Single-byte message: the byte is not in the buffer yet.
                            msg_ready_q <= 1'b0;
                            hs_strobe_q <= 1'b1;
                            hs_byte_q   <= msg_byte;
                            rd_idx_q    <= CW'(1);
                            state_q     <= SEND;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (buf_we) begin
                            cnt_q <= cnt_d;
                        end else begin
                            err_ovf_q <= 1'b1;
                        end
                        if (msg_last) begin
                            // rd_idx_q is 0 here, so buf_rd_data is the first byte.
                            msg_ready_q <= 1'b0;
                            hs_strobe_q <= 1'b1;
                            hs_byte_q   <= buf_rd_data;
                            rd_idx_q    <= CW'(1);
                            state_q     <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (rd_idx_q < cnt_q) begin
                        hs_byte_q <= buf_rd_data;
                        rd_idx_q  <= rd_idx_q + CW'(1);
                    end else begin
                        hs_strobe_q <= 1'b0;
                        hs_byte_q   <= '0;
                        rd_idx_q    <= '0;
                        tmr_q       <= TW'(TIMEOUT_CYCLES - 1);
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (hs_dig_valid) begin
                        digest_q <= digest_d;
                        beat_q   <= 6'd1;
                        state_q  <= CAPTURE;
                    end else if (tmr_q == '0) begin
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        msg_ready_q   <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                CAPTURE: begin
                    if (hs_dig_valid) begin
                        digest_q <= digest_d;
                        beat_q   <= beat_q + 6'd1;
                        if (last_beat) begin
                            digest_done_q <= 1'b1;
                            state_q       <= DONE;
                        end
                    end else begin
                        err_short_q <= 1'b1;
                        busy_q      <= 1'b0;
                        msg_ready_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                DONE: begin
                    busy_q      <= 1'b0;
                    msg_ready_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign msg_ready   = msg_ready_q;
    assign hs_byte     = hs_byte_q;
    assign hs_strobe   = hs_strobe_q;
    assign digest      = digest_q;
    assign digest_done = digest_done_q;
    assign busy        = busy_q;
    assign err_ovf     = err_ovf_q;
    assign err_timeout = err_timeout_q;
    assign err_short   = err_short_q;

endmodule

// File: tb/tb_sha256_stream_master.sv
// Directed bench with a behavioural SHA-256 hasher model and a per-cycle compare.
module tb_sha256_stream_master;

    localparam int MAXB = 55;
    localparam int TMO  = 1024;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] ZERO_DIG = 256'h6e340b9cffb37a989ca544e6bb780a2c78901d3fb33738768511a30617afa01d;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   msg_byte = 8'h00;
    logic         msg_valid = 1'b0;
    logic         msg_last = 1'b0;
    logic         msg_ready;
    logic [7:0]   hs_byte;
    logic         hs_strobe;
    logic [7:0]   hs_dig_byte = 8'h00;
    logic         hs_dig_valid = 1'b0;
    logic [255:0] digest;
    logic         digest_done;
    logic         busy;
    logic         err_ovf;
    logic         err_timeout;
    logic         err_short;

    sha256_stream_master #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_byte     (msg_byte),
        .msg_valid    (msg_valid),
        .msg_last     (msg_last),
        .msg_ready    (msg_ready),
        .hs_byte      (hs_byte),
        .hs_strobe    (hs_strobe),
        .hs_dig_byte  (hs_dig_byte),
        .hs_dig_valid (hs_dig_valid),
        .digest       (digest),
        .digest_done  (digest_done),
        .busy         (busy),
        .err_ovf      (err_ovf),
        .err_timeout  (err_timeout),
        .err_short    (err_short)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]   msg_q[$];
    logic [7:0]   exp_msg[$];
    logic [255:0] exp_digest;
    int           send_idx;
    int           done_cnt;
    int           hm_beats_cfg;
    logic [7:0]   hm_rx[$];
    logic [255:0] hm_digest;
    int           hm_delay;
    int           hm_beat;
    bit           hm_resp;
    bit           hm_prev_strobe;
    bit           exp_done_next;
    bit           in_wait;
    int           wait_cnt;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain single-block SHA-256 of a message of at most 55 bytes.
    function automatic logic [255:0] sha256_one(input logic [7:0] m[$]);
        logic [7:0]  blk [64];
        logic [31:0] w [64];
        logic [31:0] hh [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        int          n;
        n = m.size();
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < n; i++) blk[i] = m[i];
        blk[n]  = 8'h80;
        blk[62] = 8'((n * 8) >> 8);
        blk[63] = 8'(n * 8);
        for (int t = 0; t < 16; t++) w[t] = {blk[4*t], blk[4*t+1], blk[4*t+2], blk[4*t+3]};
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) hh[i] = H0[i];
        a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hh[0] + a, hh[1] + b, hh[2] + c, hh[3] + d, hh[4] + e, hh[5] + f, hh[6] + g, hh[7] + h};
    endfunction

    // Hasher model plus per-cycle compare, both on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hm_rx.delete();
                hm_resp = 0; hm_prev_strobe = 0; exp_done_next = 0; in_wait = 0;
                send_idx = 0;
                hs_dig_valid = 1'b0; hs_dig_byte = 8'h00;
                continue;
            end
            if (in_wait) begin
                wait_cnt++;
                if (wait_cnt == TMO) begin
                    chk("timeout_early", 256'(err_timeout), 256'(0));
                    chk("busy_wait_1024", 256'(busy), 256'(1));
                end
                if (wait_cnt == TMO + 1) begin
                    chk("timeout_set", 256'(err_timeout), 256'(1));
                    chk("busy_after_timeout", 256'(busy), 256'(0));
                    in_wait = 0;
                end
            end
            if (hs_strobe) begin
                if (send_idx < exp_msg.size()) chk("hs_byte", 256'(hs_byte), 256'(exp_msg[send_idx]));
                else chk("burst_overrun", 256'(send_idx + 1), 256'(exp_msg.size()));
                chk("ready_in_send", 256'(msg_ready), 256'(0));
                send_idx++;
                hm_rx.push_back(hs_byte);
            end else if (hm_prev_strobe) begin
                chk("burst_len", 256'(send_idx), 256'(exp_msg.size()));
                hm_digest = sha256_one(hm_rx);
                hm_rx.delete();
                hm_resp = 1; hm_delay = 3; hm_beat = 0;
                if (hm_beats_cfg == 0) begin in_wait = 1; wait_cnt = 1; end
            end
            chk("digest_done", 256'(digest_done), 256'(exp_done_next));
            if (digest_done) begin
                done_cnt++;
                chk("digest", digest, exp_digest);
                chk("busy_at_done", 256'(busy), 256'(1));
            end
            exp_done_next = 0;
            hs_dig_valid = 1'b0;
            hs_dig_byte  = 8'h00;
            if (hm_resp) begin
                if (hm_delay > 0) hm_delay--;
                else if (hm_beat < hm_beats_cfg) begin
                    hs_dig_valid = 1'b1;
                    hs_dig_byte  = hm_digest[255 - 8*hm_beat -: 8];
                    hm_beat++;
                    if (hm_beat == 32) begin exp_done_next = 1; hm_resp = 0; end
                end else hm_resp = 0;
            end
            hm_prev_strobe = hs_strobe;
        end
    end

    task automatic send_msg(input int beats);
        hm_beats_cfg = beats;
        exp_msg.delete();
        for (int i = 0; i < msg_q.size() && i < MAXB; i++) exp_msg.push_back(msg_q[i]);
        exp_digest = sha256_one(exp_msg);
        done_cnt = 0;
        send_idx = 0;
        for (int i = 0; i < msg_q.size(); i++) begin
            @(posedge clk); #1;
            msg_valid = 1'b1;
            msg_byte  = msg_q[i];
            msg_last  = (i == msg_q.size() - 1);
            @(negedge clk);
            chk("msg_ready", 256'(msg_ready), 256'(1));
        end
        @(posedge clk); #1;
        msg_valid = 1'b0; msg_last = 1'b0; msg_byte = 8'h00;
        @(negedge clk);
        chk("first_strobe", 256'(hs_strobe), 256'(1));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic end_check(input string tag, input int dones, input bit ovf, input bit tmo, input bit shrt);
        chk({tag, "_dones"}, 256'(done_cnt), 256'(dones));
        chk({tag, "_err_ovf"}, 256'(err_ovf), 256'(ovf));
        chk({tag, "_err_timeout"}, 256'(err_timeout), 256'(tmo));
        chk({tag, "_err_short"}, 256'(err_short), 256'(shrt));
    endtask

    task automatic load_abc();
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    endtask

    task automatic check_reset_outputs(input string tag, input bit ready);
        chk({tag, "_msg_ready"}, 256'(msg_ready), 256'(ready));
        chk({tag, "_hs_strobe"}, 256'(hs_strobe), 256'(0));
        chk({tag, "_hs_byte"}, 256'(hs_byte), 256'(0));
        chk({tag, "_digest"}, digest, 256'(0));
        chk({tag, "_done"}, 256'(digest_done), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_flags"}, 256'({err_ovf, err_timeout, err_short}), 256'(0));
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [255:0] prev_dig;
        logic [7:0]   zq[$];

        // Pin the model against known vectors.
        load_abc();
        chk("model_abc", sha256_one(msg_q), ABC_DIG);
        zq.push_back(8'h00);
        chk("model_zero", sha256_one(zq), ZERO_DIG);

        #12;
        check_reset_outputs("reset", 1'b0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 256'(msg_ready), 256'(1));

        // "abc"
        load_abc();
        send_msg(32);
        wait_idle(200);
        chk("abc_digest_literal", digest, ABC_DIG);
        end_check("abc", 1, 0, 0, 0);

        // Single zero byte
        msg_q.delete(); msg_q.push_back(8'h00);
        send_msg(32);
        wait_idle(200);
        chk("zero_digest_literal", digest, ZERO_DIG);
        end_check("zero", 1, 0, 0, 0);

        // 60-byte message, last five bytes dropped
        msg_q.delete();
        for (int i = 0; i < 60; i++) msg_q.push_back(8'(i * 7 + 3));
        send_msg(32);
        wait_idle(300);
        end_check("ovf", 1, 1, 0, 0);
        prev_dig = exp_digest;

        // Silent hasher: timeout
        load_abc();
        send_msg(0);
        wait_idle(TMO + 100);
        end_check("timeout", 0, 1, 1, 0);

        // Hasher drops valid after 20 beats
        msg_q.delete();
        for (int i = 1; i <= 5; i++) msg_q.push_back(8'(i));
        send_msg(20);
        wait_idle(200);
        end_check("short", 0, 1, 1, 1);
        chk("partial_digest", digest, {prev_dig[95:0], exp_digest[255:96]});

        load_abc();
        send_msg(32);
        wait_idle(200);
        chk("after_short_digest", digest, ABC_DIG);
        end_check("after_short", 1, 1, 1, 1);

        // Reset in the middle of SEND
        msg_q.delete();
        for (int i = 0; i < 10; i++) msg_q.push_back(8'(8'hA0 + i));
        send_msg(32);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsend_reset", 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_ready", 256'(msg_ready), 256'(1));
        chk("post_reset_digest", digest, 256'(0));
        load_abc();
        send_msg(32);
        wait_idle(200);
        chk("post_reset_abc", digest, ABC_DIG);
        end_check("post_reset", 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
